// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC main sequencer: state encoding, default sizing
// and a one-hot to index helper.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CLONE = 3'd3,
    ST_ARB   = 3'd4,
    ST_WRITE = 3'd5,
    ST_ERROR = 3'd6,
    ST_BAD   = 3'd7
  } state_e;

  localparam int DEF_N_REQ    = 2;
  localparam int DEF_POLL_DIV = 1000;
  localparam int DEF_TO_W     = 16;
  localparam int DEF_TO_CYC   = 50000;
  localparam int N_REQ_MAX    = 8;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] oh_index(input logic [N_REQ_MAX-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_REQ_MAX - 1; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rtc_rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first request at or after the
// pointer; pointer moves past the served channel on an advance strobe.
module rtc_rr_arbiter
  import rtc_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [N_REQ-1:0] adv_grant,
  output logic [N_REQ-1:0] grant
);

  logic [2:0]         ptr_q;
  logic [3:0]         ptr_inc;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   oh_rot;
  logic [2*N_REQ-1:0] g2;

  // Rotate so the pointer sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot     = N_REQ'({req, req} >> ptr_q);
    oh_rot  = rot & (~rot + N_REQ'(1));
    g2      = {{N_REQ{1'b0}}, oh_rot} << ptr_q;
    grant   = g2[N_REQ-1:0] | g2[2*N_REQ-1:N_REQ];
    ptr_inc = {1'b0, oh_index(N_REQ_MAX'(adv_grant))} + 4'd1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (ptr_inc >= 4'(N_REQ)) ? 3'd0 : ptr_inc[2:0];
    end
  end

endmodule

// File: rtl/rtc_main_sequencer.sv
// RTC controller top-level sequencer: init -> periodic read -> clone -> serve one request.
// Define RTC_SEQ_TIMEOUT_EN to add the handshake watchdog with ERROR recovery.
module rtc_main_sequencer
  import rtc_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int POLL_DIV = DEF_POLL_DIV,
  parameter int TO_W     = DEF_TO_W,
  parameter int TO_CYC   = DEF_TO_CYC
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             init_done,
  input  logic             read_done,
  input  logic             wr_done,
  input  logic [N_REQ-1:0] req,
  input  logic             err_clr,
  output logic             init_start,
  output logic             read_start,
  output logic             clone,
  output logic             wr_start,
  output logic [N_REQ-1:0] wr_sel,
  output logic [N_REQ-1:0] req_ack,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state_o
);

  localparam int CNT_W = $clog2(POLL_DIV);

  if (N_REQ < 1 || N_REQ > N_REQ_MAX || POLL_DIV < 2 || TO_CYC < 2 ||
      longint'(TO_CYC) >= (longint'(1) << TO_W)) begin : g_bad_cfg
    $error("rtc_main_sequencer: illegal parameter set");
  end

  // Handshakes: each *_start is a one-cycle request on state entry; the matching
  // *_done is accepted in any later cycle of that state. req is a level held
  // until its one-cycle req_ack.
  state_e           state_q;
  state_e           nxt;
  logic             boot_q;
  logic             entering;
  logic             init_ok;
  logic             read_ok;
  logic             wr_ok;
  logic             to_hit;
  logic             advance;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] grant;

  rtc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .CLK       (CLK),
    .reset     (reset),
    .req       (req),
    .advance   (advance),
    .adv_grant (wr_sel),
    .grant     (grant)
  );

`ifdef RTC_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] wd_q;
  logic            waiting;

  assign waiting = (state_q == ST_INIT) || (state_q == ST_READ) || (state_q == ST_WRITE);
  assign to_hit  = waiting && (wd_q == TO_W'(TO_CYC - 1));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
      err  <= 1'b0;
    end else begin
      wd_q <= (!boot_q && waiting && (nxt == state_q)) ? wd_q + TO_W'(1) : '0;
      if (nxt == ST_ERROR) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;

  assign to_hit         = 1'b0;
  assign err            = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  // boot_q marks the cycle between reset release and the first INIT entry pulse.
  always_comb begin
    nxt     = state_q;
    init_ok = init_done && !init_start && !boot_q;
    read_ok = read_done && !read_start;
    wr_ok   = wr_done && !wr_start;
    case (state_q)
      ST_INIT: begin
        if (init_ok)     nxt = ST_IDLE;
        else if (to_hit) nxt = ST_ERROR;
      end
      ST_IDLE: begin
        if (cnt_q == CNT_W'(POLL_DIV - 1)) nxt = ST_READ;
      end
      ST_READ: begin
        if (read_ok)     nxt = ST_CLONE;
        else if (to_hit) nxt = ST_ERROR;
      end
      ST_CLONE: nxt = ST_ARB;
      ST_ARB:   nxt = (|req) ? ST_WRITE : ST_IDLE;
      ST_WRITE: begin
        if (wr_ok)       nxt = ST_IDLE;
        else if (to_hit) nxt = ST_ERROR;
      end
      default:  nxt = ST_INIT;
    endcase
    entering = boot_q || (nxt != state_q);
    advance  = (state_q == ST_WRITE) && wr_ok;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      boot_q     <= 1'b1;
      cnt_q      <= '0;
      init_start <= 1'b0;
      read_start <= 1'b0;
      clone      <= 1'b0;
      wr_start   <= 1'b0;
      busy       <= 1'b0;
      req_ack    <= '0;
      wr_sel     <= '0;
    end else begin
      state_q    <= nxt;
      boot_q     <= 1'b0;
      cnt_q      <= (state_q == ST_IDLE && nxt == ST_IDLE) ? cnt_q + CNT_W'(1) : '0;
      init_start <= entering && (nxt == ST_INIT);
      read_start <= entering && (nxt == ST_READ);
      clone      <= (nxt == ST_CLONE);
      wr_start   <= entering && (nxt == ST_WRITE);
      busy       <= (nxt != ST_IDLE);
      req_ack    <= advance ? wr_sel : '0;
      if (state_q == ST_ARB && nxt == ST_WRITE) begin
        wr_sel <= grant;
      end else if (nxt != ST_WRITE) begin
        wr_sel <= '0;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_rtc_main_sequencer.sv
// Directed, table-driven bench for rtc_main_sequencer (N_REQ=2, POLL_DIV=8, TO_CYC=20).
// Covers both builds; the timeout section follows RTC_SEQ_TIMEOUT_EN.
module tb_rtc_main_sequencer;

  localparam int N_REQ    = 2;
  localparam int POLL_DIV = 8;
  localparam int TO_W     = 16;
  localparam int TO_CYC   = 20;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             init_done = 1'b0;
  logic             read_done = 1'b0;
  logic             wr_done = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             err_clr = 1'b0;
  logic             init_start;
  logic             read_start;
  logic             clone;
  logic             wr_start;
  logic [N_REQ-1:0] wr_sel;
  logic [N_REQ-1:0] req_ack;
  logic             busy;
  logic             err;
  logic [2:0]       state_o;

  rtc_main_sequencer #(
    .N_REQ(N_REQ), .POLL_DIV(POLL_DIV), .TO_W(TO_W), .TO_CYC(TO_CYC)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .init_done  (init_done),
    .read_done  (read_done),
    .wr_done    (wr_done),
    .req        (req),
    .err_clr    (err_clr),
    .init_start (init_start),
    .read_start (read_start),
    .clone      (clone),
    .wr_start   (wr_start),
    .wr_sel     (wr_sel),
    .req_ack    (req_ack),
    .busy       (busy),
    .err        (err),
    .state_o    (state_o)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic [N_REQ-1:0] req;
    int               pre;
    int               wr_lat;
    bit               drop;
    logic [N_REQ-1:0] exp_sel;
  } vec_t;

  vec_t             vecs[8];
  logic [N_REQ-1:0] exp_q[$];
  int               total = 0;
  int               bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Starts on the first IDLE cycle; ends on the first WRITE cycle (or the IDLE after ARB).
  task automatic go_to_write(input logic [N_REQ-1:0] r, input int pre,
                             input logic [N_REQ-1:0] exp_sel);
    for (int i = 0; i < POLL_DIV; i++) begin
      if (i == 0) begin
        check("idle_state", 32'(state_o), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
      end
      if (i == 1) check("ack_width", 32'(req_ack), 32'd0);
      if (i == pre) req = r;
      step();
    end
    check("read_start", 32'(read_start), 32'd1);
    check("no_early_wr", 32'(wr_start), 32'd0);
    step();
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("clone", 32'(clone), 32'd1);
    check("clone_state", 32'(state_o), 32'd3);
    step();
    check("arb_state", 32'(state_o), 32'd4);
    check("clone_width", 32'(clone), 32'd0);
    step();
    if (exp_sel == '0) begin
      check("arb_idle", 32'(state_o), 32'd1);
      check("no_wr", 32'(wr_start), 32'd0);
    end else begin
      check("wr_state", 32'(state_o), 32'd5);
      check("wr_start", 32'(wr_start), 32'd1);
      check("wr_sel", 32'(wr_sel), 32'(exp_sel));
      check("wr_busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic run_loop(input vec_t v);
    logic [N_REQ-1:0] ack;
    go_to_write(v.req, v.pre, v.exp_sel);
    if (v.exp_sel != '0) begin
      exp_q.push_back(v.exp_sel);
      for (int j = 0; j < v.wr_lat; j++) begin
        if (v.drop && j == 0) req = '0;
        step();
        check("wr_hold_sel", 32'(wr_sel), 32'(v.exp_sel));
        check("wr_start_width", 32'(wr_start), 32'd0);
        check("wr_wait_state", 32'(state_o), 32'd5);
      end
      wr_done = 1'b1;
      step();
      wr_done = 1'b0;
      ack = exp_q.pop_front();
      check("req_ack", 32'(req_ack), 32'(ack));
      check("sel_clear", 32'(wr_sel), 32'd0);
      check("back_idle", 32'(state_o), 32'd1);
      req = req & ~req_ack;
    end
  endtask

  initial begin
    int count;

    vecs[0] = '{2'b11, 0, 3, 1'b0, 2'b01};
    vecs[1] = '{2'b11, 2, 1, 1'b0, 2'b10};
    vecs[2] = '{2'b11, 0, 4, 1'b0, 2'b01};
    vecs[3] = '{2'b01, 7, 2, 1'b0, 2'b01};
    vecs[4] = '{2'b10, 3, 2, 1'b1, 2'b10};
    vecs[5] = '{2'b00, 0, 1, 1'b0, 2'b00};
    vecs[6] = '{2'b10, 5, 1, 1'b0, 2'b10};
    vecs[7] = '{2'b01, 1, 1, 1'b0, 2'b01};

    // reset state and INIT -> IDLE -> READ latency
    repeat (2) step();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_init_start", 32'(init_start), 32'd0);
    check("rst_outputs", 32'({read_start, clone, wr_start, wr_sel, req_ack, err}), 32'd0);
    reset = 1'b1;
    step();
    check("init_start", 32'(init_start), 32'd1);
    check("init_busy", 32'(busy), 32'd1);
    repeat (5) step();
    check("init_start_width", 32'(init_start), 32'd0);
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    check("idle_after_init", 32'(state_o), 32'd1);
    count = 1;
    while (!read_start && count < 20) begin
      step();
      count++;
    end
    check("read_latency", 32'(count), 32'd9);

    // read_done in the READ entry cycle is ignored
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("read_entry_ignored", 32'(state_o), 32'd2);
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check("clone_after_read", 32'(clone), 32'd1);
    step();
    check("arb_state0", 32'(state_o), 32'd4);
    step();
    check("arb_noreq_idle", 32'(state_o), 32'd1);
    check("arb_noreq_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 8; k++) run_loop(vecs[k]);

    // write handshake that never completes; pointer is 1 here
    go_to_write(2'b11, 0, 2'b10);
    repeat (TO_CYC - 1) step();
    check("wr_wait_long", 32'(state_o), 32'd5);
    step();
`ifdef RTC_SEQ_TIMEOUT_EN
    check("to_error_state", 32'(state_o), 32'd6);
    check("to_err", 32'(err), 32'd1);
    check("to_sel_clear", 32'(wr_sel), 32'd0);
    check("to_no_ack", 32'(req_ack), 32'd0);
    step();
    check("to_reinit_state", 32'(state_o), 32'd0);
    check("to_init_start", 32'(init_start), 32'd1);
    check("to_err_sticky", 32'(err), 32'd1);
    check("to_no_ack2", 32'(req_ack), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    run_loop('{2'b11, 0, 1, 1'b0, 2'b10});
`else
    check("no_to_state", 32'(state_o), 32'd5);
    check("no_to_err", 32'(err), 32'd0);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("late_ack", 32'(req_ack), 32'd2);
    check("late_idle", 32'(state_o), 32'd1);
    req = req & ~req_ack;
    run_loop('{2'b11, 0, 1, 1'b0, 2'b01});
`endif

    // reset in the middle of WRITE
    go_to_write(2'b01, 0, 2'b01);
    step();
    #2 reset = 1'b0;
    #1;
    check("rstmid_state", 32'(state_o), 32'd0);
    check("rstmid_outputs",
          32'({init_start, read_start, clone, wr_start, wr_sel, req_ack, busy, err}), 32'd0);
    step();
    req = '0;
    reset = 1'b1;
    step();
    check("rstmid_init_start", 32'(init_start), 32'd1);
    check("rstmid_init_state", 32'(state_o), 32'd0);
    step();
    check("rstmid_init_once", 32'(init_start), 32'd0);
    check("rstmid_no_ack", 32'(req_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/rtc_main_sequencer.md
Name: rtc_main_sequencer

Overview:
- Parametrised top-level sequencer for the RTC controller. It performs the initialise → periodic read → clone → serve-user-request loop.
- Generalised to N user request channels with round-robin arbitration.
- Explicit start/done handshakes to the init, read and write sub-blocks.
- Programmable poll period and an optional watchdog timeout with error recovery.

Parameters:
- N_REQ, 2, number of user request channels (1..8).
- POLL_DIV, 1000, IDLE cycles between RTC reads (≥2).
- TO_W, 16, width of watchdog counter.
- TO_CYC, 50000, handshake timeout in cycles (< 2^TO_W); used only with the macro.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_done  in  1  init sub-block finished (1-cycle pulse or level).
- read_done  in  1  read sub-block finished.
- wr_done  in  1  write sub-block finished.
- req  in  N_REQ  user request levels, held until acked.
- err_clr  in  1  clears sticky err.
- init_start  out  1  1-cycle start pulse to init sub-block.
- read_start  out  1  1-cycle start pulse to read sub-block.
- clone  out  1  1-cycle pulse: copy read registers to display shadow.
- wr_start  out  1  1-cycle start pulse to write sub-block.
- wr_sel  out  N_REQ  one-hot granted channel, stable for all of WRITE.
- req_ack  out  N_REQ  1-cycle ack on granted channel at write completion.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag.
- state_o  out  3  current state encoding.

Behaviour:
- All outputs are registered, Moore-style.
- Reset (reset=0, async):
  - state=INIT; poll counter, watchdog, rr pointer = 0.
  - All outputs 0.
  - init_start pulses in the first cycle after reset release.
- State encodings: INIT=0, IDLE=1, READ=2, CLONE=3, ARB=4, WRITE=5, ERROR=6. Encoding 7 → INIT next cycle, all pulses 0.
- Entry pulses: init_start, read_start and wr_start are high only in the first cycle of INIT, READ and WRITE respectively.
- Done sampling: a done input is ignored in its state's entry cycle and sampled from the second cycle on. Dones arriving in any other state are ignored.
- INIT: init_done → IDLE.
- IDLE:
  - Poll counter is 0 on entry and increments each cycle.
  - At count POLL_DIV-1 → READ.
  - Requests are not served from IDLE.
- READ: read_done → CLONE.
- CLONE: clone=1 for exactly one cycle → ARB.
- ARB:
  - If req==0 → IDLE.
  - Otherwise grant the first set bit at or after rr pointer, wrapping modulo N_REQ.
  - Latch the grant into wr_sel → WRITE.
- WRITE:
  - wr_done → pulse req_ack[grant] in the cycle state returns to IDLE.
  - rr pointer = (grant+1) mod N_REQ.
  - wr_sel clears in that same cycle.
  - A req bit dropping during WRITE does not abort the write.
- Simultaneous events: a request and a poll tick in the same IDLE cycle → READ first (the read always precedes service). More than one req set → exactly one grant per loop iteration.
- Latency: init_done sampled at cycle t → IDLE at t+1 → read_start at t+1+POLL_DIV.
- Reset mid-operation aborts immediately: no ack, pulses drop asynchronously.
- err_clr clears err the next cycle. If a new timeout occurs in the same cycle, set wins.

Optional Feature:
- Macro: RTC_SEQ_TIMEOUT_EN.
- Defined:
  - Watchdog clears on entry to INIT, READ and WRITE, then counts each cycle while waiting.
  - Reaching TO_CYC-1 with no done → ERROR: err=1, wr_sel=0, no ack.
  - ERROR lasts one cycle → INIT (full re-init). The rr pointer is kept.
- Undefined:
  - No watchdog logic; waits are unbounded.
  - err tied 0; ERROR is unreachable and is treated as illegal → INIT.

Decomposition:
- Package rtc_pkg:
  - state encoding localparams (3-bit);
  - default POLL_DIV, TO_CYC and N_REQ_MAX.
- Sub-module rtc_rr_arbiter (N_REQ): combinational grant from req and pointer, registered pointer update on an advance strobe.

Test Plan:
- Reset release, init_done 5 cycles after init_start, POLL_DIV=8 → read_start exactly 9 cycles after the init_done sample; clone 1 cycle after read_done.
- req=2'b11, pointer 0, three consecutive loops → grants ch0, ch1, ch0. Each req_ack is one cycle wide, and wr_sel is constant during WRITE.
- req asserted in the same IDLE cycle as the poll tick → read_start precedes wr_start. No request activity with req=0 → returns to IDLE after ARB.
- read_done pulsed in the READ entry cycle only → ignored, state stays READ. A later pulse → CLONE.
- With macro, TO_CYC=20, wr_done never asserted → ERROR after 20 WRITE cycles, err=1, no ack, then init_start next cycle. err_clr → err=0.
- reset asserted mid-WRITE → all outputs 0 immediately, state_o=0; after release, init_start pulses once.
